// File: rtl/wb_stage_pipe.sv
// Registered write-back stage: captures one retiring instruction, waits for load
// data when needed, aligns/extends it and issues a one-cycle register-file write.
// Optional trace outputs are enabled with the WB_TRACE_EN macro.
module wb_stage_pipe #(
  parameter int REG_LOG  = 5,
  parameter int CNT_W    = 32,
  parameter int LINK_OFF = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_pc,
  input  logic [REG_LOG-1:0] in_rd,
  input  logic               in_rf_we,
  input  logic [1:0]         in_res_sel,
  input  logic [2:0]         in_ld_type,
  input  logic [31:0]        in_cal_res,
  input  logic               mem_rvalid,
  input  logic [31:0]        mem_rdata,
  output logic               rf_we,
  output logic [REG_LOG-1:0] rf_waddr,
  output logic [31:0]        rf_wdata,
  output logic [CNT_W-1:0]   commit_cnt
`ifdef WB_TRACE_EN
  ,
  output logic [31:0]        debug_wb_pc,
  output logic [3:0]         debug_wb_rf_we,
  output logic [REG_LOG-1:0] debug_wb_rf_wnum,
  output logic [31:0]        debug_wb_rf_wdata
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WRITE} state_t;

  typedef enum logic [2:0] {
    LD_W  = 3'b000,
    LD_H  = 3'b001,
    LD_HU = 3'b010,
    LD_B  = 3'b011,
    LD_BU = 3'b100
  } ld_type_t;

  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_LINK = 2'b10;

  state_t               state, next_state;
  logic                 accept;
  logic                 is_load;
  logic [31:0]          direct_res;
  logic                 wr_en_q;

  // Fields of a load parked until its data arrives.
  logic [REG_LOG-1:0]   pend_rd;
  logic                 pend_we;
  logic [2:0]           pend_ld_type;
  logic [1:0]           pend_addr;

  function automatic logic [31:0] load_align(input logic [31:0] raw,
                                             input logic [2:0]  ld_type,
                                             input logic [1:0]  addr);
    logic [15:0] half;
    logic [7:0]  byte_v;
    half = addr[1] ? raw[31:16] : raw[15:0];
    case (addr)
      2'd0:    byte_v = raw[7:0];
      2'd1:    byte_v = raw[15:8];
      2'd2:    byte_v = raw[23:16];
      default: byte_v = raw[31:24];
    endcase
    case (ld_type)
      LD_H:    load_align = {{16{half[15]}}, half};
      LD_HU:   load_align = {16'h0000, half};
      LD_B:    load_align = {{24{byte_v[7]}}, byte_v};
      LD_BU:   load_align = {24'h000000, byte_v};
      default: load_align = raw;
    endcase
  endfunction

  assign in_ready = (state != S_WAIT);
  assign accept   = in_valid && in_ready;
  assign is_load  = (in_res_sel == RES_LOAD);
  assign rf_we    = (state == S_WRITE) && wr_en_q;

  // Reserved select 11 falls through to the ALU result.
  always_comb begin
    if (in_res_sel == RES_LINK) direct_res = in_pc + 32'(LINK_OFF);
    else                        direct_res = in_cal_res;
  end

  // NOTE: every variable driven here gets its default first so no latch is inferred.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: begin
        if (accept) next_state = is_load ? S_WAIT : S_WRITE;
      end
      S_WAIT: begin
        if (mem_rvalid) next_state = S_WRITE;
      end
      S_WRITE: begin
        if (accept) next_state = is_load ? S_WAIT : S_WRITE;
        else        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= next_state;
  end

  // Reset returns to IDLE, which drops any pending load and blocks a stale write.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_rd      <= '0;
      pend_we      <= 1'b0;
      pend_ld_type <= '0;
      pend_addr    <= '0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      wr_en_q      <= 1'b0;
    end else if (accept) begin
      pend_rd      <= in_rd;
      pend_we      <= in_rf_we && (in_rd != '0);
      pend_ld_type <= in_ld_type;
      pend_addr    <= in_cal_res[1:0];
      if (!is_load) begin
        rf_waddr <= in_rd;
        rf_wdata <= direct_res;
        wr_en_q  <= in_rf_we && (in_rd != '0);
      end
    end else if (state == S_WAIT && mem_rvalid) begin
      rf_waddr <= pend_rd;
      rf_wdata <= load_align(mem_rdata, pend_ld_type, pend_addr);
      wr_en_q  <= pend_we;
    end
  end

  // Counts every instruction leaving WRITE, including rd=0 or non-writing ones.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                 commit_cnt <= '0;
    else if (state == S_WRITE) commit_cnt <= commit_cnt + CNT_W'(1);
  end

`ifdef WB_TRACE_EN
  logic [31:0] pend_pc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_pc     <= '0;
      debug_wb_pc <= '0;
    end else if (accept) begin
      pend_pc <= in_pc;
      if (!is_load) debug_wb_pc <= in_pc;
    end else if (state == S_WAIT && mem_rvalid) begin
      debug_wb_pc <= pend_pc;
    end
  end

  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
`endif

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Scoreboard bench for wb_stage_pipe: expected writes are queued as stimulus is
// driven and popped when the DUT pulses rf_we; a CNT_W=4 copy checks counter wrap.
module tb_wb_stage_pipe;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready, in_ready4;
  logic [31:0] in_pc;
  logic [4:0]  in_rd;
  logic        in_rf_we;
  logic [1:0]  in_res_sel;
  logic [2:0]  in_ld_type;
  logic [31:0] in_cal_res;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_we, rf_we4;
  logic [4:0]  rf_waddr, rf_waddr4;
  logic [31:0] rf_wdata, rf_wdata4;
  logic [31:0] commit_cnt;
  logic [3:0]  commit_cnt4;
`ifdef WB_TRACE_EN
  logic [31:0] debug_wb_pc, debug_wb_pc4;
  logic [3:0]  debug_wb_rf_we, debug_wb_rf_we4;
  logic [4:0]  debug_wb_rf_wnum, debug_wb_rf_wnum4;
  logic [31:0] debug_wb_rf_wdata, debug_wb_rf_wdata4;
`endif

  always #5 clk = ~clk;

  wb_stage_pipe #(.REG_LOG(5), .CNT_W(32), .LINK_OFF(4)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rd(in_rd), .in_rf_we(in_rf_we), .in_res_sel(in_res_sel),
    .in_ld_type(in_ld_type), .in_cal_res(in_cal_res), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .commit_cnt(commit_cnt)
`ifdef WB_TRACE_EN
    , .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
`endif
  );

  // Same stimulus, narrow counter: only commit_cnt4 is observed.
  wb_stage_pipe #(.REG_LOG(5), .CNT_W(4), .LINK_OFF(4)) dut_w4 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready4),
    .in_pc(in_pc), .in_rd(in_rd), .in_rf_we(in_rf_we), .in_res_sel(in_res_sel),
    .in_ld_type(in_ld_type), .in_cal_res(in_cal_res), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .rf_we(rf_we4), .rf_waddr(rf_waddr4), .rf_wdata(rf_wdata4),
    .commit_cnt(commit_cnt4)
`ifdef WB_TRACE_EN
    , .debug_wb_pc(debug_wb_pc4), .debug_wb_rf_we(debug_wb_rf_we4),
    .debug_wb_rf_wnum(debug_wb_rf_wnum4), .debug_wb_rf_wdata(debug_wb_rf_wdata4)
`endif
  );

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
  } wr_t;

  wr_t         sb_q[$];
  int          wr_cycles[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          model_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every rf_we pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (rstn && rf_we) begin
      wr_cycles.push_back(cyc);
      if (sb_q.size() == 0) begin
        check("unexpected_write", {27'd0, rf_waddr}, 32'hDEAD_BEEF);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        check("wr_addr", {27'd0, rf_waddr}, {27'd0, e.addr});
        check("wr_data", rf_wdata, e.data);
`ifdef WB_TRACE_EN
        check("trace_pc", debug_wb_pc, e.pc);
        check("trace_we", {28'd0, debug_wb_rf_we}, 32'hF);
        check("trace_wdata", debug_wb_rf_wdata, e.data);
`endif
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [31:0] pc, input logic [4:0] rd, input logic we,
                       input logic [1:0] sel, input logic [2:0] ldt, input logic [31:0] cal);
    int   n;
    logic rdy;
    n = 0;
    in_valid = 1'b1; in_pc = pc; in_rd = rd; in_rf_we = we;
    in_res_sel = sel; in_ld_type = ldt; in_cal_res = cal;
    do begin
      rdy = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 100);
    if (!rdy) check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    model_cnt++;
    if (sel != 2'b01 && we && rd != 5'd0)
      sb_q.push_back('{addr: rd, data: (sel == 2'b10) ? pc + 32'd4 : cal, pc: pc});
  endtask

  // Load with data returned 'gap' cycles after acceptance.
  task automatic load(input logic [31:0] pc, input logic [4:0] rd, input logic [2:0] ldt,
                      input logic [31:0] addr, input logic [31:0] rdata, input logic [31:0] exp,
                      input int gap);
    issue(pc, rd, 1'b1, 2'b01, ldt, addr);
    for (int i = 1; i < gap; i++) begin
      check("ready_low_wait", {31'd0, in_ready}, 32'd0);
      tick(1);
    end
    mem_rdata = rdata;
    mem_rvalid = 1'b1;
    sb_q.push_back('{addr: rd, data: exp, pc: pc});
    tick(1);
    mem_rvalid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_we"}, {31'd0, rf_we}, 32'd0);
    check({tag, "_waddr"}, {27'd0, rf_waddr}, 32'd0);
    check({tag, "_wdata"}, rf_wdata, 32'd0);
    check({tag, "_cnt"}, commit_cnt, 32'd0);
`ifdef WB_TRACE_EN
    check({tag, "_trace_pc"}, debug_wb_pc, 32'd0);
`endif
  endtask

  initial begin
    rstn = 1'b0; in_valid = 1'b0; in_pc = '0; in_rd = '0; in_rf_we = 1'b0;
    in_res_sel = '0; in_ld_type = '0; in_cal_res = '0; mem_rvalid = 1'b0; mem_rdata = '0;
    #3;
    check_reset_outputs("por");
    #9 rstn = 1'b1;
    tick(1);

    // Back-to-back ALU ops.
    wr_cycles.delete();
    issue(32'h100, 5'd1, 1'b1, 2'b00, 3'b000, 32'h11);
    issue(32'h104, 5'd2, 1'b1, 2'b00, 3'b000, 32'h22);
    issue(32'h108, 5'd3, 1'b1, 2'b00, 3'b000, 32'h33);
    tick(3);
    check("b2b_writes", wr_cycles.size(), 32'd3);
    if (wr_cycles.size() == 3) check("b2b_span", wr_cycles[2] - wr_cycles[0], 32'd2);
    check("cnt_alu3", commit_cnt, 32'd3);

    // Sub-word and word loads.
    load(32'h200, 5'd4, 3'b011, 32'h1003, 32'h80FF7F01, 32'hFFFFFF80, 4);
    load(32'h204, 5'd5, 3'b100, 32'h1003, 32'h80FF7F01, 32'h00000080, 4);
    load(32'h208, 5'd6, 3'b001, 32'h2002, 32'h8001ABCD, 32'hFFFF8001, 2);
    load(32'h20C, 5'd7, 3'b010, 32'h2002, 32'h8001ABCD, 32'h00008001, 1);
    load(32'h210, 5'd8, 3'b000, 32'h2000, 32'h8001ABCD, 32'h8001ABCD, 3);
    load(32'h214, 5'd9, 3'b011, 32'h3001, 32'h12345678, 32'h00000056, 1);
    tick(2);

    // Link results, including the 32-bit wrap, then rd=0 suppression.
    issue(32'h1C000000, 5'd1, 1'b1, 2'b10, 3'b000, 32'h0);
    issue(32'hFFFFFFFC, 5'd10, 1'b1, 2'b10, 3'b000, 32'h0);
    issue(32'h300, 5'd0, 1'b1, 2'b00, 3'b000, 32'hABCD);
    issue(32'h304, 5'd11, 1'b0, 2'b11, 3'b000, 32'h77);
    tick(3);
    check("cnt_mixed", commit_cnt, model_cnt);

    // Spurious rvalid while idle.
    mem_rdata = 32'hFFFFFFFF;
    mem_rvalid = 1'b1;
    tick(2);
    check("ready_spurious", {31'd0, in_ready}, 32'd1);
    mem_rvalid = 1'b0;
    issue(32'h400, 5'd12, 1'b1, 2'b00, 3'b000, 32'h55);
    tick(3);
    check("cnt_spurious", commit_cnt, model_cnt);

    // Reset while a load is waiting.
    issue(32'h500, 5'd13, 1'b1, 2'b01, 3'b000, 32'h0);
    tick(2);
    #2 rstn = 1'b0;
    #1;
    check_reset_outputs("rst_wait");
    #3 rstn = 1'b1;
    model_cnt = 0;
    tick(1);
    mem_rdata = 32'h13572468;
    mem_rvalid = 1'b1;
    tick(1);
    mem_rvalid = 1'b0;
    check("no_write_after_rst", {31'd0, rf_we}, 32'd0);
    tick(3);
    check("cnt_after_rst", commit_cnt, 32'd0);

    // 17 retirements: narrow counter wraps to 1.
    for (int i = 0; i < 17; i++)
      issue(32'h600 + 32'(i * 4), 5'(i % 31 + 1), 1'b1, 2'b00, 3'b000, 32'(i * 32'h101));
    tick(3);
    check("cnt_wide_17", commit_cnt, 32'd17);
    check("cnt_wrap_w4", {28'd0, commit_cnt4}, 32'(model_cnt % 16));

    tick(2);
    check("sb_drained", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_stage_pipe.md
Name: wb_stage_pipe

Overview:
- Registered write-back stage between the MEM stage and the register file.
- Latches one retiring instruction through a valid/ready handshake and selects the result source: ALU result, load data or link address.
- Aligns and extends load data that may arrive a variable number of cycles later, then drives a one-cycle register-file write.
- Parametrised successor of the combinational write-back mux; adds buffering, multi-cycle load wait, sub-word loads and a retire counter.

Parameters:
- REG_LOG, 5, register index width (register file depth is 2**REG_LOG).
- CNT_W, 32, width of the retired-instruction counter.
- LINK_OFF, 4, offset added to the PC for link results.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rstn  input  1  asynchronous reset, active-low.
- in_valid  input  1  MEM stage presents an instruction.
- in_ready  output  1  stage can accept this cycle.
- in_pc  input  32  instruction PC.
- in_rd  input  REG_LOG  destination register.
- in_rf_we  input  1  instruction writes rd.
- in_res_sel  input  2  result source: 00 ALU, 01 load, 10 PC+LINK_OFF, 11 reserved (treated as ALU).
- in_ld_type  input  3  load type: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU; others treated as LW.
- in_cal_res  input  32  ALU result, or effective address when loading.
- mem_rvalid  input  1  load data valid strobe.
- mem_rdata  input  32  raw load word.
- rf_we  output  1  register-file write enable.
- rf_waddr  output  REG_LOG  write index.
- rf_wdata  output  32  write data.
- commit_cnt  output  CNT_W  count of retired instructions.

Behaviour:
- Reset (rstn=0, asynchronous):
  - state=IDLE; rf_we=0, rf_waddr=0, rf_wdata=0, commit_cnt=0; in_ready=1.
  - Any pending load is discarded.
- Accept: an instruction is accepted on the edge where in_valid=1 and in_ready=1; all in_* fields are captured.
- States:
  - IDLE: in_ready=1. Accept with res_sel!=01 -> WRITE. Accept with res_sel=01 -> WAIT. No accept -> stay in IDLE. mem_rvalid is ignored.
  - WAIT: in_ready=0. When mem_rvalid=1, latch the aligned load data -> WRITE. Otherwise stay in WAIT indefinitely.
  - WRITE: one cycle only. rf_we = captured rf_we AND (rd!=0); rf_waddr and rf_wdata are registered values. in_ready=1. commit_cnt increments by 1, wrapping modulo 2**CNT_W; this counts every retired instruction, writing or not. Next state: accept non-load -> WRITE, accept load -> WAIT, no accept -> IDLE. mem_rvalid is ignored.
- Outside WRITE: rf_we=0; rf_waddr and rf_wdata hold their last values.
- Latency:
  - Non-load accepted at edge N: write visible in cycle N+1.
  - Back-to-back non-loads: throughput of 1 per cycle.
  - Load: write visible in the cycle after the mem_rvalid edge. mem_rvalid may arrive no earlier than the cycle after acceptance.
- Load alignment uses a = in_cal_res[1:0]:
  - LW: the whole word.
  - LH/LHU: halfword selected by a[1]; a[0] is ignored (misalignment is trapped upstream).
  - LB/LBU: byte a.
  - LH and LB sign-extend; LHU and LBU zero-extend.
- Link result: in_pc + LINK_OFF, truncated to 32 bits (0xFFFFFFFC+4 = 0).
- rd=0 with rf_we=1: no write is issued, but the instruction is still counted.
- Reset asserted in WAIT or WRITE: the write is aborted, with no rf_we pulse after rstn deasserts.

Optional Feature:
- Macro WB_TRACE_EN.
- Defined: adds outputs
  - debug_wb_pc (32): registered PC of the retiring instruction.
  - debug_wb_rf_we (4): rf_we replicated 4 times.
  - debug_wb_rf_wnum (REG_LOG): equals rf_waddr.
  - debug_wb_rf_wdata (32): equals rf_wdata.
  - All valid in WRITE; reset to 0.
- Undefined: these ports and their registers are absent; all other behaviour is identical.

Test Plan:
- Reset, then 3 back-to-back ALU ops (rd=1,2,3; cal_res=0x11,0x22,0x33) -> rf_we high for 3 consecutive cycles, writing the right data; commit_cnt=3.
- LB with cal_res=0x1003 and mem_rvalid 4 cycles later with mem_rdata=0x80FF7F01 -> in_ready=0 during the wait; wdata=0xFFFFFF80 one cycle after rvalid. The same case with LBU -> 0x00000080.
- LH/LHU with addr 0x2002 and rdata=0x8001ABCD -> 0xFFFF8001 and 0x00008001 respectively; LW -> 0x8001ABCD.
- Link with pc=0x1C000000, rd=1 -> wdata=0x1C000004. ALU op with rd=0, rf_we=1 -> rf_we stays 0 and commit_cnt still increments.
- Spurious mem_rvalid in IDLE followed by an accepted ALU op -> no extra write and state unaffected. rstn pulsed low in WAIT -> outputs reset, and a later rvalid causes no write.
- CNT_W=4, 17 retirements -> commit_cnt=1 (wrap). With WB_TRACE_EN defined, debug_wb_pc matches each retiring PC.
